async_fifo: RTL and testbench
=============================

ASYNC_FIFO -- requirements
Module: async_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of wdata and rdata.
REQ-002 Parameter DEPTH, default 8: number of storage entries; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; every register updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-005 wr  input  1  write request.
REQ-006 rd  input  1  read request.
REQ-007 wdata  input  DATA_WIDTH  write data, sampled on a clk edge when a write is accepted.
REQ-008 rdata  output  DATA_WIDTH  registered read data.
REQ-009 full  output  1  high when DEPTH entries are stored.
REQ-010 empty  output  1  high when 0 entries are stored.
REQ-011 overflow  output  1  write-rejected error flag.
REQ-012 underflow  output  1  read-rejected error flag.

Function
REQ-013 Pointers SHALL be log2(DEPTH)+1 bits wide, with the MSB used as a wrap bit.
  - empty = (wptr == rptr).
  - full = address bits equal and wrap bits differ.
REQ-014 Write acceptance: a write is accepted when wr=1 and full=0.
  - mem[wptr] <= wdata and wptr increments.
REQ-015 Read acceptance: a read is accepted when rd=1 and empty=0.
  - rdata <= mem[rptr] on the same edge and rptr increments.
  - Data is visible one cycle after the request.
REQ-016 rdata SHALL hold its last value when no read is accepted.
REQ-017 full and empty SHALL be derived combinationally from the registered pointers, so they update in the cycle after the accepting edge.
REQ-018 Data SHALL be returned in strict write order.
  - Pointers wrap modulo DEPTH, and the wrap bit toggles on each wrap.
REQ-019 Simultaneous wr and rd, neither full nor empty: both are accepted and the occupancy is unchanged.
REQ-020 Simultaneous wr and rd while empty: the write is accepted and the read is rejected.
REQ-021 Simultaneous wr and rd while full: the read is accepted and the write is rejected.
  - full is evaluated before the read.
REQ-022 overflow SHALL go high on the edge following a cycle with wr=1 and full=1; the rejected data is discarded.
REQ-023 underflow SHALL go high on the edge following a cycle with rd=1 and empty=1.
  - The pointers and rdata are unchanged.

Reset
REQ-024 While rst=0, asynchronously:
  - wptr = 0 and rptr = 0;
  - rdata = 0;
  - empty = 1, full = 0;
  - overflow = 0, underflow = 0.
REQ-025 Memory contents are not reset; contents after reset are don't-care and SHALL never appear on rdata.
REQ-026 Reset mid-operation discards all stored data; the first read after reset returns the first word written after reset.
REQ-027 wr and rd are ignored while rst=0.

Configuration
REQ-028 Macro ASYNC_FIFO_STICKY_ERR_EN controls the error flags.
  - Defined: overflow and underflow are sticky and stay high until reset.
  - Undefined: each flag is a single-cycle pulse per rejected request, recomputed every cycle.

Verification
REQ-029 Reset: hold rst=0 for 2 cycles -> empty=1, full=0, rdata=0, overflow=0, underflow=0.
REQ-030 Fill to full: write 0..7 on 8 consecutive cycles -> full=1 after the 8th edge; a 9th write of 0xAA -> overflow=1, and 0xAA is never read.
REQ-031 Drain in order: read 8 times -> rdata = 0,1,...,7, each one cycle after its request; empty=1 after the 8th edge; a further read -> underflow=1, rdata holds 7.
REQ-032 Wrap-around: write 5, read 5, then write 8 (0x10..0x17) and read 8 -> output is 0x10..0x17 in order, with full/empty correct across the wrap.
REQ-033 Simultaneous events: with 3 entries stored, assert wr+rd for 4 cycles -> occupancy stays 3 and order is preserved; when empty, wr+rd -> 1 entry stored and underflow=1.
REQ-034 Reset mid-operation: write 4 entries, pulse rst=0 asynchronously (between edges) -> flags reset immediately; after release, write 0x55 and read -> rdata=0x55.

Source files
------------

// File: rtl/async_fifo.sv
// Single-clock FIFO with wrap-bit pointers, registered read data and error flags.
// Define ASYNC_FIFO_STICKY_ERR_EN to make overflow/underflow sticky until reset.
module async_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           wptr;
  logic [AW:0]           rptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  ovf_hit;
  logic                  unf_hit;

  // Handshake: wr is the request, !full its ready; a write is taken on an edge
  // where wr && !full. Likewise a read is taken where rd && !empty, and rdata
  // carries that word from the edge onwards. Refused requests only raise a flag.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign wr_ok   = wr && !full;
  assign rd_ok   = rd && !empty;
  assign ovf_hit = wr && full;
  assign unf_hit = rd && empty;

  // Storage has no reset; the rst gate keeps writes inert while reset is held.
  always_ff @(posedge clk) begin
    if (wr_ok && rst) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      rdata     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rdata <= mem[rptr[AW-1:0]];
        rptr  <= rptr + 1'b1;
      end
`ifdef ASYNC_FIFO_STICKY_ERR_EN
      overflow  <= overflow  | ovf_hit;
      underflow <= underflow | unf_hit;
`else
      overflow  <= ovf_hit;
      underflow <= unf_hit;
`endif
    end
  end

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo: queue-based reference model compared every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_async_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic          wr;
  logic          rd;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;

  int n_vec = 0;
  int n_err = 0;

  async_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr        (wr),
    .rd        (rd),
    .wdata     (wdata),
    .rdata     (rdata),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: FIFO contents as a queue, outputs from occupancy
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_rdata;
  logic          m_ovf;
  logic          m_unf;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      m_rdata = '0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      logic ovf_now;
      logic unf_now;
      ovf_now = wr && (exp_q.size() == DEPTH);
      unf_now = rd && (exp_q.size() == 0);
      if (rd && exp_q.size() > 0) m_rdata = exp_q.pop_front();
      if (wr && !ovf_now) exp_q.push_back(wdata);
`ifdef ASYNC_FIFO_STICKY_ERR_EN
      m_ovf = m_ovf | ovf_now;
      m_unf = m_unf | unf_now;
`else
      m_ovf = ovf_now;
      m_unf = unf_now;
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare on every falling edge
  always @(negedge clk) begin
    check("m_rdata",     32'(rdata),     32'(m_rdata));
    check("m_full",      32'(full),      32'(exp_q.size() == DEPTH));
    check("m_empty",     32'(empty),     32'(exp_q.size() == 0));
    check("m_overflow",  32'(overflow),  32'(m_ovf));
    check("m_underflow", 32'(underflow), 32'(m_unf));
  end

  // driver: apply one cycle of inputs, return 2 time units after the edge
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    wr    = w;
    rd    = r;
    wdata = d;
    @(posedge clk);
    #2;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  initial begin
    // reset held 2 cycles with requests asserted; they must be ignored
    rst   = 1'b0;
    wr    = 1'b1;
    rd    = 1'b1;
    wdata = 8'hEE;
    repeat (2) @(posedge clk);
    #2;
    wr = 1'b0;
    rd = 1'b0;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_ovf",   32'(overflow),  32'd0);
    check("rst_unf",   32'(underflow), 32'd0);
    rst = 1'b1;

    // fill to full, then overflow
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(i));
    check("fill_full",  32'(full),  32'd1);
    check("fill_empty", 32'(empty), 32'd0);
    step(1'b1, 1'b0, 8'hAA);
    check("fill_ovf",   32'(overflow), 32'd1);
    check("fill_full2", 32'(full),     32'd1);

    // drain in order, then underflow
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check("drain_data", 32'(rdata), 32'(i));
    end
    check("drain_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b1, 8'h00);
    check("drain_unf",  32'(underflow), 32'd1);
    check("drain_hold", 32'(rdata),     32'd7);

    // wrap-around
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check("wrap_pre", 32'(rdata), 32'(8'h20 + i));
    end
    check("wrap_empty0", 32'(empty), 32'd1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    check("wrap_full", 32'(full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check("wrap_data", 32'(rdata), 32'(8'h10 + i));
    end
    check("wrap_empty", 32'(empty), 32'd1);
    check("wrap_nfull", 32'(full),  32'd0);

    // simultaneous wr+rd with 3 stored
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 8'(8'h40 + i));
      check("sim_data", 32'(rdata), (i < 3) ? 32'(8'h30 + i) : 32'h40);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check("sim_tail", 32'(rdata), 32'(8'h41 + i));
    end
    check("sim_empty", 32'(empty), 32'd1);
    step(1'b1, 1'b1, 8'h77);
    check("sim_e_unf",   32'(underflow), 32'd1);
    check("sim_e_empty", 32'(empty),     32'd0);
    step(1'b0, 1'b1, 8'h00);
    check("sim_e_data",  32'(rdata), 32'h77);
    check("sim_e_empty2", 32'(empty), 32'd1);

    // simultaneous wr+rd while full: read wins, write rejected
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
    step(1'b1, 1'b1, 8'hBB);
    check("sfull_data", 32'(rdata),    32'h80);
    check("sfull_ovf",  32'(overflow), 32'd1);
    check("sfull_full", 32'(full),     32'd0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check("sfull_tail", 32'(rdata), 32'(8'h81 + i));
    end
    check("sfull_empty", 32'(empty), 32'd1);

    // reset mid-operation, asserted and released between edges
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
    #1 rst = 1'b0;
    #1;
    check("mid_empty", 32'(empty),     32'd1);
    check("mid_full",  32'(full),      32'd0);
    check("mid_rdata", 32'(rdata),     32'd0);
    check("mid_ovf",   32'(overflow),  32'd0);
    check("mid_unf",   32'(underflow), 32'd0);
    #3 rst = 1'b1;
    step(1'b1, 1'b0, 8'h55);
    step(1'b0, 1'b1, 8'h00);
    check("mid_data",   32'(rdata), 32'h55);
    check("mid_empty2", 32'(empty), 32'd1);

    repeat (2) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
